bus_switch: RTL

//  Parametrised, registered successor to the 4:1/16:1 byte mux and 1:4/1:16 demux.

---
 rtl/bus_switch_pkg.sv | 14 +
 rtl/bus_switch_rr_arbiter.sv | 30 +++
 rtl/bus_switch.sv | 110 +++++++++++
 3 files changed

// File: rtl/bus_switch_pkg.sv
// Shared mode encodings and helpers for the bus_switch source-to-destination crossbar.
package bus_switch_pkg;

  localparam int MODE_MANUAL = 0;
  localparam int MODE_PRIO   = 1;
  localparam int MODE_RR     = 2;

  // One-hot decode of idx into a 16-bit vector; indices at or beyond n decode to zero.
  function automatic logic [15:0] onehot_dec(input logic [3:0] idx, input int n);
    onehot_dec = '0;
    if (int'(idx) < n) onehot_dec[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/bus_switch_rr_arbiter.sv
// Rotating-priority arbiter: first request at or above i_ptr wins, wrapping modulo N.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);

  int v_c;

  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    v_c   = 0;
    for (int k = 0; k < N; k++) begin
      v_c = (int'(i_ptr) + k) % N;
      if (!o_any && i_req[v_c]) begin
        o_any = 1'b1;
        o_idx = IW'(v_c);
      end
    end
    if (o_any) o_gnt[o_idx] = 1'b1;
  end

endmodule

// File: rtl/bus_switch.sv
// Arbitrates N_SRC requesters onto one registered output word and steers it to a
// one-hot destination write enable.
module bus_switch
  import bus_switch_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int N_SRC = 4,
  parameter int N_DST = 4,
  parameter int MODE  = 2,
  parameter int SRC_W = $clog2(N_SRC),
  parameter int DST_W = $clog2(N_DST)
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [N_SRC-1:0]       i_req,
  input  logic [N_SRC*WIDTH-1:0] i_in_data,
  input  logic [N_SRC*DST_W-1:0] i_in_dst,
  input  logic [SRC_W-1:0]       i_sel,
  input  logic                   i_out_ready,
  output logic [N_SRC-1:0]       o_gnt,
  output logic                   o_out_valid,
  output logic [WIDTH-1:0]       o_out_data,
  output logic [SRC_W-1:0]       o_out_src,
  output logic [N_DST-1:0]       o_out_we,
  output logic                   o_out_err
);

  localparam int NP = 1 << SRC_W;

  logic             w_adv, w_any, w_grant, w_err, w_arb_any;
  logic [N_SRC-1:0] w_arb_gnt, w_win_oh;
  logic [SRC_W-1:0] w_arb_idx, w_win, w_ptr;
  logic [NP-1:0]    w_req_pad;
  logic [WIDTH-1:0] w_data;
  logic [DST_W-1:0] w_dst;
  logic [N_DST-1:0] w_we;

  logic             r_valid, r_err;
  logic [WIDTH-1:0] r_data;
  logic [SRC_W-1:0] r_src, r_rr_ptr;
  logic [N_DST-1:0] r_we;

  assign w_req_pad = NP'(i_req);
  assign w_ptr     = (MODE == MODE_RR) ? r_rr_ptr : '0;

  rr_arbiter #(.N(N_SRC), .IW(SRC_W)) u_arb (
    .i_req (i_req),
    .i_ptr (w_ptr),
    .o_gnt (w_arb_gnt),
    .o_idx (w_arb_idx),
    .o_any (w_arb_any)
  );

  // Manual mode bypasses the arbiter; the padded request vector makes an out-of-range SEL read as no request.
  always_comb begin
    w_any    = 1'b0;
    w_win    = '0;
    w_win_oh = '0;
    if (MODE == MODE_MANUAL) begin
      w_any    = w_req_pad[i_sel];
      w_win    = i_sel;
      w_win_oh = N_SRC'(1) << i_sel;
    end else begin
      w_any    = w_arb_any;
      w_win    = w_arb_idx;
      w_win_oh = w_arb_gnt;
    end
  end

  assign w_adv   = !r_valid || i_out_ready;
  assign w_grant = !i_rst && w_adv && w_any;
  assign o_gnt   = w_grant ? w_win_oh : '0;

  assign w_data = i_in_data[w_win*WIDTH +: WIDTH];
  assign w_dst  = i_in_dst[w_win*DST_W +: DST_W];
  assign w_err  = int'(w_dst) >= N_DST;
  assign w_we   = w_err ? '0 : N_DST'(onehot_dec(4'(w_dst), N_DST));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid  <= 1'b0;
      r_data   <= '0;
      r_src    <= '0;
      r_we     <= '0;
      r_err    <= 1'b0;
      r_rr_ptr <= '0;
    end else if (w_adv) begin
      if (w_any) begin
        r_valid <= 1'b1;
        r_data  <= w_data;
        r_src   <= w_win;
        r_we    <= w_we;
        r_err   <= w_err;
        if (MODE == MODE_RR)
          r_rr_ptr <= (int'(w_win) == N_SRC - 1) ? '0 : w_win + 1'b1;
      end else begin
        r_valid <= 1'b0;
        r_we    <= '0;
        r_err   <= 1'b0;
      end
    end
  end

  assign o_out_valid = r_valid;
  assign o_out_data  = r_data;
  assign o_out_src   = r_src;
  assign o_out_we    = r_we;
  assign o_out_err   = r_err;

endmodule
